tmds_word_aligner: RTL and testbench

//  Receive-side word aligner for one TMDS channel, the counterpart of the 10:1 transmit serializer.

---
 rtl/tmds_word_aligner.sv | 124 ++++++++++++
 tb/tb_tmds_word_aligner.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tmds_word_aligner.sv
// Receive-side TMDS word aligner: hunts for control tokens across the ten bit offsets,
// slips one bit per search timeout, and reports lock once a run of tokens lines up.
module tmds_word_aligner #(
    parameter int CTRL_LOCK_COUNT = 8,
    parameter int SEARCH_TIMEOUT  = 4096,
    parameter int LOSS_TIMEOUT    = 65536
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic [9:0] raw_word,
    output logic [9:0] aligned_word,
    output logic       ctrl_detect,
    output logic       locked,
    output logic [3:0] slip_offset
);

    localparam int DW = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int RW = $clog2(CTRL_LOCK_COUNT) + 1;
    localparam int LW = $clog2(LOSS_TIMEOUT) + 1;

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t        state, state_n;
    logic [9:0]    prev;
    logic [DW-1:0] dwell, dwell_n;
    logic [RW-1:0] run, run_n;
    logic [LW-1:0] loss, loss_n;
    logic [3:0]    offset_n, offset_inc;
    logic          locked_n;
    logic [19:0]   window;
    logic [9:0]    cand;
    logic          is_tok;

    // Older word sits in the low half so bit 0 stays the earliest bit on the wire.
    always_comb begin
        window     = {raw_word, prev};
        cand       = window[slip_offset +: 10];
        is_tok     = (cand == 10'h354) || (cand == 10'h0AB) ||
                     (cand == 10'h154) || (cand == 10'h2AB);
        offset_inc = (slip_offset == 4'd9) ? 4'd0 : slip_offset + 4'd1;
    end

    always_comb begin
        state_n  = state;
        dwell_n  = dwell;
        run_n    = run;
        loss_n   = loss;
        offset_n = slip_offset;
        locked_n = locked;
        case (state)
            SEARCH: begin
                dwell_n = dwell + 1'b1;
                if (is_tok) begin
                    state_n = VERIFY;
                    run_n   = RW'(1);
                end else if (dwell == DW'(SEARCH_TIMEOUT - 1)) begin
                    offset_n = offset_inc;
                    dwell_n  = '0;
                end
            end
            VERIFY: begin
                dwell_n = dwell + 1'b1;
                // Completing the run beats the dwell timeout on the same cycle.
                if (is_tok && (run + 1'b1 == RW'(CTRL_LOCK_COUNT))) begin
                    state_n  = LOCKED;
                    run_n    = '0;
                    locked_n = 1'b1;
                    loss_n   = '0;
                end else if (dwell == DW'(SEARCH_TIMEOUT - 1)) begin
                    state_n  = SEARCH;
                    run_n    = '0;
                    offset_n = offset_inc;
                    dwell_n  = '0;
                end else if (is_tok) begin
                    run_n = run + 1'b1;
                end else begin
                    state_n = SEARCH;
                    run_n   = '0;
                end
            end
            LOCKED: begin
                if (is_tok) begin
                    loss_n = '0;
                end else if (loss == LW'(LOSS_TIMEOUT - 1)) begin
                    state_n  = SEARCH;
                    locked_n = 1'b0;
                    loss_n   = '0;
                    offset_n = offset_inc;
                    dwell_n  = '0;
                end else begin
                    loss_n = loss + 1'b1;
                end
            end
            default: begin
                state_n = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state        <= SEARCH;
            prev         <= '0;
            dwell        <= '0;
            run          <= '0;
            loss         <= '0;
            slip_offset  <= '0;
            locked       <= 1'b0;
            aligned_word <= '0;
            ctrl_detect  <= 1'b0;
        end else begin
            state        <= state_n;
            prev         <= raw_word;
            dwell        <= dwell_n;
            run          <= run_n;
            loss         <= loss_n;
            slip_offset  <= offset_n;
            locked       <= locked_n;
            aligned_word <= cand;
            ctrl_detect  <= is_tok;
        end
    end

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner: symbol streams are framed at a chosen bit offset
// and lock/slip/loss timing is checked against hand-counted cycle numbers.
module tb_tmds_word_aligner;

    logic       clk_pixel = 1'b0;
    logic       reset_n   = 1'b0;
    logic [9:0] raw_word  = '0;
    logic [9:0] aligned_word;
    logic       ctrl_detect;
    logic       locked;
    logic [3:0] slip_offset;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         k       = 0;
    logic [9:0] last_sym = '0;

    localparam logic [9:0] T0   = 10'h354;
    localparam logic [9:0] T1   = 10'h0AB;
    localparam logic [9:0] T2   = 10'h154;
    localparam logic [9:0] T3   = 10'h2AB;
    localparam logic [9:0] DATA = 10'h1F0;

    tmds_word_aligner #(
        .CTRL_LOCK_COUNT(4),
        .SEARCH_TIMEOUT (16),
        .LOSS_TIMEOUT   (64)
    ) dut (
        .clk_pixel   (clk_pixel),
        .reset_n     (reset_n),
        .raw_word    (raw_word),
        .aligned_word(aligned_word),
        .ctrl_detect (ctrl_detect),
        .locked      (locked),
        .slip_offset (slip_offset)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one symbol framed so that it begins at bit k of the raw word,
    // then sample just after the capturing edge.
    task automatic step(input logic [9:0] sym);
        logic [19:0] pair;
        pair     = {sym, last_sym};
        raw_word = pair[10-k +: 10];
        @(posedge clk_pixel);
        #1;
        last_sym = sym;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(10'h000);
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_aligned", aligned_word, 10'h000);
        chk("rst_ctrl", {9'b0, ctrl_detect}, 10'd0);
        chk("rst_locked", {9'b0, locked}, 10'd0);
        chk("rst_offset", {6'b0, slip_offset}, 10'd0);

        // 1: 0x354 stream at offset 3
        k = 3;
        for (int n = 0; n < 56; n++) begin
            step(T0);
            if (n == 14) chk("t1_off_e14", {6'b0, slip_offset}, 10'd0);
            if (n == 15) chk("t1_off_e15", {6'b0, slip_offset}, 10'd1);
            if (n == 31) chk("t1_off_e31", {6'b0, slip_offset}, 10'd2);
            if (n == 47) chk("t1_off_e47", {6'b0, slip_offset}, 10'd3);
            if (n == 50) chk("t1_unlocked_e50", {9'b0, locked}, 10'd0);
            if (n == 51) begin
                chk("t1_locked_e51", {9'b0, locked}, 10'd1);
                chk("t1_aligned", aligned_word, T0);
                chk("t1_ctrl", {9'b0, ctrl_detect}, 10'd1);
            end
        end

        // 2: VERIFY aborted by a data word, then relock
        do_reset();
        k = 0;
        step(T1); step(T2);
        chk("t2_aligned_tok", aligned_word, T1);
        chk("t2_ctrl_tok", {9'b0, ctrl_detect}, 10'd1);
        step(DATA);
        step(T3);
        chk("t2_aligned_data", aligned_word, DATA);
        chk("t2_ctrl_data", {9'b0, ctrl_detect}, 10'd0);
        chk("t2_abort_locked", {9'b0, locked}, 10'd0);
        chk("t2_abort_offset", {6'b0, slip_offset}, 10'd0);
        step(T0); step(T3); step(T1);
        chk("t2_relock_e6", {9'b0, locked}, 10'd0);
        step(T2);
        chk("t2_relock_e7", {9'b0, locked}, 10'd1);
        chk("t2_relock_off", {6'b0, slip_offset}, 10'd0);

        // 3: locked at offset 5; a token at data cycle 40 refreshes the loss timer
        do_reset();
        k = 5;
        for (int n = 0; n < 84; n++) begin
            step(T0);
            if (n == 79) chk("t3_off5", {6'b0, slip_offset}, 10'd5);
            if (n == 83) chk("t3_locked", {9'b0, locked}, 10'd1);
        end
        for (int j = 0; j < 106; j++) begin
            step((j == 40) ? T2 : DATA);
            if (j == 64)  chk("t3_kept_j64", {9'b0, locked}, 10'd1);
            if (j == 104) chk("t3_kept_j104", {9'b0, locked}, 10'd1);
            if (j == 105) begin
                chk("t3_lost_j105", {9'b0, locked}, 10'd0);
                chk("t3_slip6", {6'b0, slip_offset}, 10'd6);
            end
        end

        // 4: lock at offset 9, lose it (wraps to 0), relock on a re-framed stream
        do_reset();
        k = 9;
        for (int n = 0; n < 148; n++) begin
            step(T0);
            if (n == 143) chk("t4_off9", {6'b0, slip_offset}, 10'd9);
            if (n == 147) chk("t4_locked", {9'b0, locked}, 10'd1);
        end
        for (int j = 0; j < 65; j++) begin
            step(DATA);
            if (j == 63) chk("t4_hold_j63", {9'b0, locked}, 10'd1);
            if (j == 64) begin
                chk("t4_lost_j64", {9'b0, locked}, 10'd0);
                chk("t4_wrap0", {6'b0, slip_offset}, 10'd0);
            end
        end
        k = 0;
        for (int t = 0; t < 5; t++) begin
            step(T1);
            if (t == 3) chk("t4_relock_t3", {9'b0, locked}, 10'd0);
            if (t == 4) begin
                chk("t4_relock_t4", {9'b0, locked}, 10'd1);
                chk("t4_relock_off", {6'b0, slip_offset}, 10'd0);
            end
        end

        // 5: token exactly on the search timeout cycle
        do_reset();
        k = 0;
        for (int n = 0; n < 19; n++) begin
            step((n < 14) ? DATA : T0);
            if (n == 14) chk("t5_off_e14", {6'b0, slip_offset}, 10'd0);
            if (n == 15) chk("t5_noslip_e15", {6'b0, slip_offset}, 10'd0);
            if (n == 17) chk("t5_unlocked_e17", {9'b0, locked}, 10'd1 - 10'd1);
            if (n == 18) begin
                chk("t5_locked_e18", {9'b0, locked}, 10'd1);
                chk("t5_off_e18", {6'b0, slip_offset}, 10'd0);
            end
        end

        // 6: reset pulse while run=3 in VERIFY
        do_reset();
        k = 0;
        step(T0); step(T0); step(T0); step(T0);
        reset_n = 1'b0;
        step(T0);
        reset_n = 1'b1;
        chk("t6_aligned", aligned_word, 10'h000);
        chk("t6_ctrl", {9'b0, ctrl_detect}, 10'd0);
        chk("t6_locked", {9'b0, locked}, 10'd0);
        chk("t6_offset", {6'b0, slip_offset}, 10'd0);
        step(T0); step(T0); step(T0); step(T0);
        chk("t6_nolock_e8", {9'b0, locked}, 10'd0);
        step(T0);
        chk("t6_lock_e9", {9'b0, locked}, 10'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
